id_ex_stage: RTL and testbench
==============================

# id_ex_stage

Instruction-decode stage of the 5-stage MIPS pipeline. Takes the IF/ID instruction, drives the register-file read addresses, and decodes the control signals. It detects load-use hazards and registers operands and controls into the ID/EX pipeline register for the execute stage. It sits between the IF/ID register and the ALU, wrapped around the register-file read ports.

## Interface
- DATA_W, 32, datapath width
- REG_AW, 5, register address width
- clk  in  1  rising-edge clock
- rst  in  1  reset; synchronous, active-high
- if_id_instr  in  32  instruction from IF/ID
- if_id_pc  in  32  PC+4 of that instruction
- if_id_valid  in  1  IF/ID holds a real instruction
- src1 / src2  out  5  register-file read addresses (rs / rt), combinational
- rd_data1 / rd_data2  in  32  register-file read data (combinational read)
- wb_regwrite, wb_dst, wb_data  in  1/5/32  write-back port, mirrors register-file write inputs
- ex_flush  in  1  branch taken in EX; kill the instruction in ID
- stall  out  1  hold PC and IF/ID this cycle (combinational)
- ex_valid, ex_pc, ex_op1, ex_op2, ex_imm  out  1/32/32/32/32  registered operands
- ex_dst  out  5; ex_alu_op  out  3; ex_alu_src, ex_mem_read, ex_mem_write, ex_regwrite, ex_mem_to_reg, ex_branch  out  1 each
- stall_cnt  out  16  saturating count of load-use stall cycles

## Operation
- **Field decode:** opcode [31:26], rs [25:21], rt [20:16], rd [15:11], funct [5:0]. src1=rs, src2=rt always.
- **ALU op codes:** ADD=0, SUB=1, AND=2, OR=3, SLT=4.
- **R-type (op 0):** funct 0x20/0x22/0x24/0x25/0x2A map to ADD/SUB/AND/OR/SLT. dst=rd, regwrite=1. Any other funct decodes as NOP.
- **LW (0x23):** ADD, alu_src=1, mem_read=1, mem_to_reg=1, regwrite=1, dst=rt.
- **SW (0x2B):** ADD, alu_src=1, mem_write=1, dst=0.
- **ADDI (0x08):** ADD, alu_src=1, regwrite=1, dst=rt.
- **BEQ (0x04):** SUB, branch=1, dst=0.
- **Any other opcode:** NOP, meaning all control signals 0 and valid still passes.
- **Immediate:** instr[15:0] sign-extended to 32 bits.
- **Register 0:** an operand whose source address is 0 is forced to 0, whatever rd_data returns.
- **Load-use hazard:** stall=1 when all of the following hold:
  - ex_valid=1, ex_mem_read=1 and ex_dst≠0;
  - ex_dst==rs, or ex_dst==rt and the instruction reads rt (R-type, SW, BEQ);
  - if_id_valid=1.
- **Effect of stall:** ID/EX loads a bubble. The stall lasts exactly one cycle, because the bubble clears the hazard.
- **Bubble:** ex_valid=0, all control signals 0, ex_dst=0. Data fields are don't-care; drive them to 0.
- **Priority:** rst > ex_flush > stall > normal load. With ex_flush=1, stall is forced to 0 and a bubble is loaded.
- **Invalid input:** if_id_valid=0 loads a bubble.
- **stall_cnt:** increments on every stall cycle and saturates at 0xFFFF.

## Timing
- Operands and controls appear on ex_* one cycle after the ID cycle in which they were sampled.
- stall and src1/src2 are combinational from the current inputs and current ex_* state.
- **Reset:** every ex_* output and stall_cnt are 0 on the first edge with rst=1. stall is therefore 0 while in reset.
- **Reset mid-stall:** the stall is dropped and the pipeline register is bubbled.

## Configuration
- **ID_WB_BYPASS_EN defined:** if wb_regwrite=1, wb_dst≠0 and wb_dst equals src1 (or src2), the matching operand takes wb_data instead of rd_data. This covers the same-cycle write/read of the register file.
- **ID_WB_BYPASS_EN undefined:** operands come only from rd_data1/rd_data2 (after the register-0 rule), and the wb_* ports are unused.

## Structure
- **Package mips_pkg:**
  - opcode constants (OP_RTYPE, OP_LW, OP_SW, OP_ADDI, OP_BEQ);
  - funct constants;
  - ALU op enum;
  - control-bundle struct for the six control bits.
- **Sub-module id_decoder:** combinational instruction → control bundle, dst, and uses-rt flag.
- **Top level:** hazard logic, bypass, pipeline register and counter.

## Test plan
- **R-type:** after rst, instr 0x00221820 (add $3,$1,$2), rd_data1=1, rd_data2=4 → next cycle ex_op1=1, ex_op2=4, ex_dst=3, ex_alu_op=ADD, ex_regwrite=1, ex_valid=1.
- **Load-use:** 0x8C050008 (lw $5,8($0)) then 0x00A13020 (add $6,$5,$1) → stall=1 for exactly one cycle, a bubble in EX, add issued the following cycle, stall_cnt=1.
- **Immediate and register 0:** 0x2004FFFF (addi $4,$0,-1) with rd_data1=3 → ex_op1=0, ex_imm=0xFFFFFFFF, ex_alu_src=1, ex_dst=4.
- **Flush over stall:** ex_flush=1 in the same cycle as the load-use condition → stall=0, ex_valid=0 next cycle, stall_cnt unchanged.
- **Bypass:** wb_regwrite=1, wb_dst=2, wb_data=0x55 while decoding src2=2 with rd_data2=4 → ex_op2=0x55 with ID_WB_BYPASS_EN, ex_op2=4 without it.
- **Reset mid-operation:** assert rst while ex_valid=1 and stall=1 → all ex_* outputs 0 and stall_cnt=0 after one edge.

Source files
------------

// File: rtl/mips_pkg.sv
// mips_pkg: opcode/funct constants, ALU op encoding and control bundle shared by the ID stage.
package mips_pkg;
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] FN_ADD   = 6'h20;
  localparam logic [5:0] FN_SUB   = 6'h22;
  localparam logic [5:0] FN_AND   = 6'h24;
  localparam logic [5:0] FN_OR    = 6'h25;
  localparam logic [5:0] FN_SLT   = 6'h2A;
  typedef enum logic [2:0] {
    ALU_ADD = 3'd0,
    ALU_SUB = 3'd1,
    ALU_AND = 3'd2,
    ALU_OR  = 3'd3,
    ALU_SLT = 3'd4
  } alu_op_e;
  typedef struct packed {
    logic alu_src;
    logic mem_read;
    logic mem_write;
    logic regwrite;
    logic mem_to_reg;
    logic branch;
  } ctrl_t;
endpackage

// File: rtl/id_decoder.sv
// id_decoder: opcode/funct to control bundle, ALU op, destination register and uses-rt flag.
module id_decoder
  import mips_pkg::*;
(
  input  logic [5:0] i_op,
  input  logic [5:0] i_funct,
  input  logic [4:0] i_rt,
  input  logic [4:0] i_rd,
  output ctrl_t      o_ctrl,
  output alu_op_e    o_alu_op,
  output logic [4:0] o_dst,
  output logic       o_uses_rt
);
  logic w_fn_ok;
  assign w_fn_ok = i_funct == FN_ADD || i_funct == FN_SUB || i_funct == FN_AND ||
                   i_funct == FN_OR  || i_funct == FN_SLT;
  assign o_uses_rt = i_op == OP_RTYPE || i_op == OP_SW || i_op == OP_BEQ;
  always_comb begin
    o_ctrl   = '0;
    o_alu_op = ALU_ADD;
    o_dst    = '0;
    case (i_op)
      OP_RTYPE: if (w_fn_ok) begin
        o_alu_op = i_funct == FN_SUB ? ALU_SUB :
                   i_funct == FN_AND ? ALU_AND :
                   i_funct == FN_OR  ? ALU_OR  :
                   i_funct == FN_SLT ? ALU_SLT : ALU_ADD;
        o_ctrl.regwrite = 1'b1;
        o_dst = i_rd;
      end
      OP_LW: begin
        o_ctrl.alu_src    = 1'b1;
        o_ctrl.mem_read   = 1'b1;
        o_ctrl.mem_to_reg = 1'b1;
        o_ctrl.regwrite   = 1'b1;
        o_dst = i_rt;
      end
      OP_SW: begin
        o_ctrl.alu_src   = 1'b1;
        o_ctrl.mem_write = 1'b1;
      end
      OP_ADDI: begin
        o_ctrl.alu_src  = 1'b1;
        o_ctrl.regwrite = 1'b1;
        o_dst = i_rt;
      end
      OP_BEQ: begin
        o_alu_op      = ALU_SUB;
        o_ctrl.branch = 1'b1;
      end
      default: ;
    endcase
  end
endmodule

// File: rtl/id_ex_stage.sv
// id_ex_stage: MIPS decode stage with load-use stall, flush, ID/EX register and stall counter.
// Optional ID_WB_BYPASS_EN forwards the write-back port into same-cycle operand reads.
module id_ex_stage
  import mips_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       if_id_instr,
  input  logic [31:0]       if_id_pc,
  input  logic              if_id_valid,
  output logic [REG_AW-1:0] src1,
  output logic [REG_AW-1:0] src2,
  input  logic [DATA_W-1:0] rd_data1,
  input  logic [DATA_W-1:0] rd_data2,
  input  logic              wb_regwrite,
  input  logic [REG_AW-1:0] wb_dst,
  input  logic [DATA_W-1:0] wb_data,
  input  logic              ex_flush,
  output logic              stall,
  output logic              ex_valid,
  output logic [31:0]       ex_pc,
  output logic [DATA_W-1:0] ex_op1,
  output logic [DATA_W-1:0] ex_op2,
  output logic [DATA_W-1:0] ex_imm,
  output logic [REG_AW-1:0] ex_dst,
  output logic [2:0]        ex_alu_op,
  output logic              ex_alu_src,
  output logic              ex_mem_read,
  output logic              ex_mem_write,
  output logic              ex_regwrite,
  output logic              ex_mem_to_reg,
  output logic              ex_branch,
  output logic [15:0]       stall_cnt
);
  ctrl_t             w_ctrl, r_ctrl;
  alu_op_e           w_alu_op, r_alu_op;
  logic [4:0]        w_dst;
  logic              w_uses_rt, w_bubble;
  logic [DATA_W-1:0] w_op1, w_op2;
  logic              r_valid;
  logic [31:0]       r_pc;
  logic [DATA_W-1:0] r_op1, r_op2, r_imm;
  logic [REG_AW-1:0] r_dst;
  logic [15:0]       r_cnt;
  assign src1 = if_id_instr[25:21];
  assign src2 = if_id_instr[20:16];
  id_decoder u_dec (
    .i_op      (if_id_instr[31:26]),
    .i_funct   (if_id_instr[5:0]),
    .i_rt      (if_id_instr[20:16]),
    .i_rd      (if_id_instr[15:11]),
    .o_ctrl    (w_ctrl),
    .o_alu_op  (w_alu_op),
    .o_dst     (w_dst),
    .o_uses_rt (w_uses_rt)
  );
  assign stall = !rst && !ex_flush && if_id_valid && r_valid && r_ctrl.mem_read && r_dst != '0 &&
                 (r_dst == src1 || (w_uses_rt && r_dst == src2));
  assign w_bubble = ex_flush || stall || !if_id_valid;
`ifdef ID_WB_BYPASS_EN
  logic w_hit1, w_hit2;
  assign w_hit1 = wb_regwrite && wb_dst != '0 && wb_dst == src1;
  assign w_hit2 = wb_regwrite && wb_dst != '0 && wb_dst == src2;
  assign w_op1 = src1 == '0 ? '0 : w_hit1 ? wb_data : rd_data1;
  assign w_op2 = src2 == '0 ? '0 : w_hit2 ? wb_data : rd_data2;
`else
  logic w_unused;
  assign w_unused = ^{wb_regwrite, wb_dst, wb_data};
  assign w_op1 = src1 == '0 ? '0 : rd_data1;
  assign w_op2 = src2 == '0 ? '0 : rd_data2;
`endif
  always_ff @(posedge clk) begin
    if (rst || w_bubble) begin
      r_valid  <= 1'b0;
      r_pc     <= '0;
      r_op1    <= '0;
      r_op2    <= '0;
      r_imm    <= '0;
      r_dst    <= '0;
      r_alu_op <= ALU_ADD;
      r_ctrl   <= '0;
    end else begin
      r_valid  <= 1'b1;
      r_pc     <= if_id_pc;
      r_op1    <= w_op1;
      r_op2    <= w_op2;
      r_imm    <= DATA_W'({{(DATA_W-16){if_id_instr[15]}}, if_id_instr[15:0]});
      r_dst    <= REG_AW'(w_dst);
      r_alu_op <= w_alu_op;
      r_ctrl   <= w_ctrl;
    end
  end
  always_ff @(posedge clk)
    if (rst) r_cnt <= '0;
    else if (stall && r_cnt != 16'hFFFF) r_cnt <= r_cnt + 16'd1;
  assign ex_valid      = r_valid;
  assign ex_pc         = r_pc;
  assign ex_op1        = r_op1;
  assign ex_op2        = r_op2;
  assign ex_imm        = r_imm;
  assign ex_dst        = r_dst;
  assign ex_alu_op     = r_alu_op;
  assign ex_alu_src    = r_ctrl.alu_src;
  assign ex_mem_read   = r_ctrl.mem_read;
  assign ex_mem_write  = r_ctrl.mem_write;
  assign ex_regwrite   = r_ctrl.regwrite;
  assign ex_mem_to_reg = r_ctrl.mem_to_reg;
  assign ex_branch     = r_ctrl.branch;
  assign stall_cnt     = r_cnt;
endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage: directed plus randomized checks of id_ex_stage against a behavioural model.
module tb_id_ex_stage;
  logic clk = 0, rst = 0;
  logic [31:0] if_id_instr = 0, if_id_pc = 0, rd_data1 = 0, rd_data2 = 0, wb_data = 0;
  logic if_id_valid = 0, wb_regwrite = 0, ex_flush = 0;
  logic [4:0] wb_dst = 0;
  logic [4:0] src1, src2, ex_dst;
  logic stall, ex_valid, ex_alu_src, ex_mem_read, ex_mem_write, ex_regwrite, ex_mem_to_reg, ex_branch;
  logic [31:0] ex_pc, ex_op1, ex_op2, ex_imm;
  logic [2:0] ex_alu_op;
  logic [15:0] stall_cnt;
  int checks = 0, errors = 0;
  logic m_valid = 0;
  logic [31:0] m_pc = 0, m_op1 = 0, m_op2 = 0, m_imm = 0;
  logic [4:0] m_dst = 0;
  logic [2:0] m_aop = 0;
  logic [5:0] m_c = 0;
  logic [15:0] m_cnt = 0;
  logic m_stall;

  always #5 clk = ~clk;

  id_ex_stage dut (
    .clk(clk), .rst(rst), .if_id_instr(if_id_instr), .if_id_pc(if_id_pc), .if_id_valid(if_id_valid),
    .src1(src1), .src2(src2), .rd_data1(rd_data1), .rd_data2(rd_data2),
    .wb_regwrite(wb_regwrite), .wb_dst(wb_dst), .wb_data(wb_data), .ex_flush(ex_flush),
    .stall(stall), .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_op1(ex_op1), .ex_op2(ex_op2),
    .ex_imm(ex_imm), .ex_dst(ex_dst), .ex_alu_op(ex_alu_op), .ex_alu_src(ex_alu_src),
    .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write), .ex_regwrite(ex_regwrite),
    .ex_mem_to_reg(ex_mem_to_reg), .ex_branch(ex_branch), .stall_cnt(stall_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  // controls packed as {alu_src, mem_read, mem_write, regwrite, mem_to_reg, branch}
  task automatic decode(input logic [31:0] ins, output logic [2:0] aop, output logic [5:0] c,
                        output logic [4:0] dst, output logic rt_used);
    logic [5:0] op, fn;
    op = ins[31:26];
    fn = ins[5:0];
    aop = 0; c = 0; dst = 0;
    rt_used = (op == 6'h00) || (op == 6'h2B) || (op == 6'h04);
    if (op == 6'h00) begin
      if (fn == 6'h20 || fn == 6'h22 || fn == 6'h24 || fn == 6'h25 || fn == 6'h2A) begin
        aop = fn == 6'h20 ? 3'd0 : fn == 6'h22 ? 3'd1 : fn == 6'h24 ? 3'd2 : fn == 6'h25 ? 3'd3 : 3'd4;
        c = 6'b000100;
        dst = ins[15:11];
      end
    end else if (op == 6'h23) begin c = 6'b110110; dst = ins[20:16]; end
    else if (op == 6'h2B) c = 6'b101000;
    else if (op == 6'h08) begin c = 6'b100100; dst = ins[20:16]; end
    else if (op == 6'h04) begin aop = 3'd1; c = 6'b000001; end
  endtask

  function automatic logic [31:0] operand(input logic [4:0] a, input logic [31:0] rd,
                                          input logic w, input logic [4:0] wd, input logic [31:0] wv);
    logic bp;
`ifdef ID_WB_BYPASS_EN
    bp = 1;
`else
    bp = 0;
`endif
    if (a == 0) return 0;
    return (bp && w && wd != 0 && wd == a) ? wv : rd;
  endfunction

  task automatic step(input logic [31:0] ins, input logic v, input logic fl, input logic r,
                      input logic [31:0] d1, input logic [31:0] d2,
                      input logic wbw, input logic [4:0] wbd, input logic [31:0] wbv);
    logic [2:0] aop;
    logic [5:0] c;
    logic [4:0] dst;
    logic rtu;
    logic [31:0] pc;
    pc = $urandom;
    if_id_instr = ins; if_id_valid = v; ex_flush = fl; rst = r; if_id_pc = pc;
    rd_data1 = d1; rd_data2 = d2; wb_regwrite = wbw; wb_dst = wbd; wb_data = wbv;
    decode(ins, aop, c, dst, rtu);
    m_stall = !r && !fl && v && m_valid && m_c[4] && m_dst != 0 &&
              (m_dst == ins[25:21] || (rtu && m_dst == ins[20:16]));
    #1;
    chk("stall", {31'd0, stall}, {31'd0, m_stall});
    chk("src1", {27'd0, src1}, {27'd0, ins[25:21]});
    chk("src2", {27'd0, src2}, {27'd0, ins[20:16]});
    @(posedge clk);
    if (r) m_cnt = 0;
    else if (m_stall && m_cnt != 16'hFFFF) m_cnt++;
    if (r || fl || m_stall || !v) begin
      m_valid = 0; m_pc = 0; m_op1 = 0; m_op2 = 0; m_imm = 0; m_dst = 0; m_aop = 0; m_c = 0;
    end else begin
      m_valid = 1; m_pc = pc; m_dst = dst; m_aop = aop; m_c = c;
      m_op1 = operand(ins[25:21], d1, wbw, wbd, wbv);
      m_op2 = operand(ins[20:16], d2, wbw, wbd, wbv);
      m_imm = {{16{ins[15]}}, ins[15:0]};
    end
    #1;
    chk("ex_valid", {31'd0, ex_valid}, {31'd0, m_valid});
    chk("ex_pc", ex_pc, m_pc);
    chk("ex_op1", ex_op1, m_op1);
    chk("ex_op2", ex_op2, m_op2);
    chk("ex_imm", ex_imm, m_imm);
    chk("ex_dst", {27'd0, ex_dst}, {27'd0, m_dst});
    chk("ex_alu_op", {29'd0, ex_alu_op}, {29'd0, m_aop});
    chk("ex_ctrl", {26'd0, ex_alu_src, ex_mem_read, ex_mem_write, ex_regwrite, ex_mem_to_reg, ex_branch},
        {26'd0, m_c});
    chk("stall_cnt", {16'd0, stall_cnt}, {16'd0, m_cnt});
  endtask

  function automatic logic [31:0] rand_instr();
    logic [5:0] ops [6];
    logic [5:0] fns [6];
    ops = '{6'h00, 6'h23, 6'h2B, 6'h08, 6'h04, 6'h3F};
    fns = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A, 6'h01};
    return {ops[$urandom_range(5)], 5'($urandom_range(7)), 5'($urandom_range(7)),
            5'($urandom_range(7)), 5'($urandom), fns[$urandom_range(5)]};
  endfunction

  initial begin
    step(32'h0, 0, 0, 1, 0, 0, 0, 0, 0);
    chk("reset_valid", {31'd0, ex_valid}, 32'd0);
    chk("reset_cnt", {16'd0, stall_cnt}, 32'd0);
    step(32'h00221820, 1, 0, 0, 1, 4, 0, 0, 0);
    chk("add_op1", ex_op1, 32'd1);
    chk("add_op2", ex_op2, 32'd4);
    chk("add_dst", {27'd0, ex_dst}, 32'd3);
    chk("add_regwrite", {31'd0, ex_regwrite}, 32'd1);
    step(32'h8C050008, 1, 0, 0, 0, 7, 0, 0, 0);
    step(32'h00A13020, 1, 0, 0, 9, 2, 0, 0, 0);
    chk("lu_stall", {31'd0, m_stall}, 32'd1);
    chk("lu_bubble", {31'd0, ex_valid}, 32'd0);
    step(32'h00A13020, 1, 0, 0, 9, 2, 0, 0, 0);
    chk("lu_issue_dst", {27'd0, ex_dst}, 32'd6);
    chk("lu_cnt", {16'd0, stall_cnt}, 32'd1);
    step(32'h2004FFFF, 1, 0, 0, 3, 5, 0, 0, 0);
    chk("addi_op1", ex_op1, 32'd0);
    chk("addi_imm", ex_imm, 32'hFFFFFFFF);
    chk("addi_src", {31'd0, ex_alu_src}, 32'd1);
    chk("addi_dst", {27'd0, ex_dst}, 32'd4);
    step(32'h8C050008, 1, 0, 0, 0, 7, 0, 0, 0);
    step(32'h00A13020, 1, 1, 0, 9, 2, 0, 0, 0);
    chk("flush_valid", {31'd0, ex_valid}, 32'd0);
    chk("flush_cnt", {16'd0, stall_cnt}, 32'd1);
    step(32'h00221820, 1, 0, 0, 1, 4, 1, 5'd2, 32'h55);
`ifdef ID_WB_BYPASS_EN
    chk("bypass_op2", ex_op2, 32'h55);
`else
    chk("bypass_op2", ex_op2, 32'd4);
`endif
    step(32'h8C050008, 1, 0, 0, 0, 7, 0, 0, 0);
    step(32'h00A13020, 1, 0, 1, 9, 2, 0, 0, 0);
    chk("rst_mid_valid", {31'd0, ex_valid}, 32'd0);
    chk("rst_mid_cnt", {16'd0, stall_cnt}, 32'd0);
    for (int i = 0; i < 600; i++)
      step(rand_instr(), $urandom_range(7) != 0, $urandom_range(9) == 0, $urandom_range(59) == 0,
           $urandom, $urandom, 1'($urandom), 5'($urandom_range(7)), $urandom);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
